csi_rx_link_ctrl: RTL and testbench
===================================

CSI_RX_LINK_CTRL -- requirements
Module: csi_rx_link_ctrl

Interface
REQ-001 Parameter RST_CYCLES, 16: cycles that link_reset is held in RESET (range 1..255).
REQ-002 Parameter SYNC_TIMEOUT, 65535: cycles allowed in SYNC before recovery (range 1..2^24-1).
REQ-003 Parameter FRAME_TIMEOUT, 16777215: cycles allowed in LOCKED without a start-of-frame (range 1..2^24-1).
REQ-004 Parameter ECC_ERR_MAX, 4: consecutive ECC-errored packets that force recovery (range 1..15).
REQ-005 Port clock, input, 1: CSI byte clock; the only clock.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port enable, input, 1: camera enable from system.
REQ-008 Port clk_ok, input, 1: byte-clock-alive indication, synchronous to clock.
REQ-009 Port sync_wait, input, 1: packet handler hunting for sync; 0 means a packet header was locked.
REQ-010 Port packet_done, input, 1: one-cycle end-of-packet pulse.
REQ-011 Port ecc_err, input, 1: uncorrectable header ECC; sampled only when packet_done=1.
REQ-012 Port in_frame, input, 1: frame-active level from the packet handler.
REQ-013 Port link_reset, output, 1: active-high synchronous reset to aligners and packet handler.
REQ-014 Port link_enable, output, 1: enable to aligners and packet handler.
REQ-015 Port locked, output, 1: 1 when the FSM is in LOCKED.
REQ-016 Port state, output, 3: FSM state code.
REQ-017 Port err_irq, output, 1: one-cycle pulse on entry to RECOVER.
REQ-018 Port resync_cnt, output, 8: recovery count, saturating.
REQ-019 Port frame_cnt, output, 16: start-of-frame count, wrapping.

Function
REQ-020 State encoding SHALL be IDLE=0, RESET=1, SYNC=2, LOCKED=3, RECOVER=4; all other codes SHALL return to IDLE on the next cycle.
REQ-021 In any state, enable=0 or clk_ok=0 SHALL force IDLE on the next cycle; this condition has highest priority.
REQ-022 IDLE: link_reset=1, link_enable=0; enable=1 and clk_ok=1 SHALL go to RESET.
REQ-023 RESET: link_reset=1, link_enable=0, held for exactly RST_CYCLES cycles, then SYNC.
REQ-024 SYNC: link_reset=0, link_enable=1, timer counts from 0; sync_wait=0 SHALL go to LOCKED; timer=SYNC_TIMEOUT-1 with sync_wait=1 SHALL go to RECOVER; if both occur in the same cycle, LOCKED wins.
REQ-025 LOCKED: link_enable=1; a rising edge of in_frame (registered previous value) SHALL clear the frame watchdog and increment frame_cnt (16-bit wrap, 0xFFFF->0x0000).
REQ-026 LOCKED: watchdog reaching FRAME_TIMEOUT-1 without a start-of-frame SHALL go to RECOVER; a start-of-frame in that same cycle cancels the timeout.
REQ-027 LOCKED: packet_done with ecc_err=1 SHALL increment a 4-bit consecutive-error count; packet_done with ecc_err=0 SHALL clear it; reaching ECC_ERR_MAX SHALL go to RECOVER.
REQ-028 RECOVER lasts one cycle with link_reset=1 and link_enable=0; err_irq=1; resync_cnt increments, saturating at 255; next state is RESET.
REQ-029 All outputs SHALL be registered; a state change is visible on outputs one cycle after the causing input.
REQ-030 The timer and ECC counter SHALL clear on every state entry.

Reset
REQ-031 reset_n=0 SHALL asynchronously set: state=IDLE, link_reset=1, link_enable=0, locked=0, err_irq=0, resync_cnt=0, frame_cnt=0, and clear all internal counters.
REQ-032 Deassertion of reset_n is synchronized externally; the first FSM evaluation occurs on the first clock edge with reset_n=1.

Configuration
REQ-033 Macro CSI_LINK_STATS_EN defined: resync_cnt and frame_cnt are implemented as in REQ-025 and REQ-028.
REQ-034 Macro CSI_LINK_STATS_EN undefined: resync_cnt and frame_cnt are tied to 0 and their counters are not synthesized; FSM and err_irq are unchanged.

Verification (RST_CYCLES=4, SYNC_TIMEOUT=100, FRAME_TIMEOUT=1000, ECC_ERR_MAX=2)
REQ-035 Bring-up: enable=1, clk_ok=1, sync_wait drops 10 cycles after SYNC entry -> link_reset high for 4 cycles, then locked=1 after those 10 cycles.
REQ-036 Sync timeout: sync_wait held at 1 -> RECOVER after 100 cycles in SYNC, err_irq pulses once, resync_cnt=1, FSM re-enters RESET.
REQ-037 Frame watchdog: locked, no in_frame edge for 1000 cycles -> RECOVER; with an edge at cycle 999 -> stays LOCKED and frame_cnt increments.
REQ-038 ECC: two consecutive packet_done pulses with ecc_err=1 -> RECOVER; an error/clean/error sequence -> stays LOCKED.
REQ-039 Abort and reset: clk_ok drops in LOCKED -> IDLE next cycle with link_reset=1; reset_n pulse mid-SYNC -> all outputs return to reset values immediately.
REQ-040 Saturation and wrap: 300 forced recoveries -> resync_cnt=255; frame_cnt preloaded to 0xFFFF plus one start-of-frame -> 0x0000; with CSI_LINK_STATS_EN undefined, both read 0.

Source files
------------

// File: rtl/csi_rx_link_ctrl.sv
// csi_rx_link_ctrl: CSI-2 receive link bring-up and supervision FSM (IDLE/RESET/SYNC/LOCKED/RECOVER).
// Define CSI_LINK_STATS_EN to build the resync_cnt/frame_cnt statistics counters; otherwise they read 0.
module csi_rx_link_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int SYNC_TIMEOUT  = 65535,
  parameter int FRAME_TIMEOUT = 16777215,
  parameter int ECC_ERR_MAX   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       clk_ok,
  input  logic       sync_wait,
  input  logic       packet_done,
  input  logic       ecc_err,
  input  logic       in_frame,
  output logic       link_reset,
  output logic       link_enable,
  output logic       locked,
  output logic [2:0] state,
  output logic       err_irq,
  output logic [7:0] resync_cnt,
  output logic [15:0] frame_cnt
);
  typedef enum logic [2:0] {IDLE = 3'd0, RESET = 3'd1, SYNC = 3'd2, LOCKED = 3'd3, RECOVER = 3'd4} state_e;
  localparam logic [23:0] RST_LAST   = 24'(RST_CYCLES - 1);
  localparam logic [23:0] SYNC_LAST  = 24'(SYNC_TIMEOUT - 1);
  localparam logic [23:0] FRAME_LAST = 24'(FRAME_TIMEOUT - 1);
  localparam logic [3:0]  ECC_LIM    = 4'(ECC_ERR_MAX);
  state_e      state_q, state_d;
  logic [23:0] tmr_q, tmr_d;
  logic [3:0]  ecc_q, ecc_d;
  logic        in_frame_q, sof;
  assign sof = in_frame & ~in_frame_q;
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + 24'd1;
    ecc_d   = ecc_q;
    case (state_q)
      IDLE:    state_d = RESET;
      RESET:   state_d = (tmr_q == RST_LAST) ? SYNC : RESET;
      SYNC:    state_d = !sync_wait ? LOCKED : (tmr_q == SYNC_LAST) ? RECOVER : SYNC;
      LOCKED: begin
        if (packet_done) ecc_d = ecc_err ? ecc_q + 4'd1 : 4'd0;
        if (sof) tmr_d = '0;
        if ((packet_done && ecc_err && (ecc_q + 4'd1 == ECC_LIM)) || (!sof && tmr_q == FRAME_LAST))
          state_d = RECOVER;
      end
      RECOVER: state_d = RESET;
      default: state_d = IDLE;
    endcase
    if (!enable || !clk_ok) state_d = IDLE;
    if (state_d != state_q) begin
      tmr_d = '0;
      ecc_d = '0;
    end
  end
  // Outputs are decoded from the next state so they line up with the registered state code.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      ecc_q       <= '0;
      in_frame_q  <= 1'b0;
      link_reset  <= 1'b1;
      link_enable <= 1'b0;
      locked      <= 1'b0;
      err_irq     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      ecc_q       <= ecc_d;
      in_frame_q  <= in_frame;
      link_reset  <= !(state_d == SYNC || state_d == LOCKED);
      link_enable <= state_d == SYNC || state_d == LOCKED;
      locked      <= state_d == LOCKED;
      err_irq     <= state_d == RECOVER;
    end
  end
  assign state = state_q;
`ifdef CSI_LINK_STATS_EN
  logic [7:0]  resync_cnt_q;
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resync_cnt_q <= '0;
      frame_cnt_q  <= '0;
    end else begin
      if (state_d == RECOVER && resync_cnt_q != 8'hFF) resync_cnt_q <= resync_cnt_q + 8'd1;
      if (state_q == LOCKED && sof) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end
  assign resync_cnt = resync_cnt_q;
  assign frame_cnt  = frame_cnt_q;
`else
  assign resync_cnt = '0;
  assign frame_cnt  = '0;
`endif
endmodule

// File: tb/tb_csi_rx_link_ctrl.sv
// tb_csi_rx_link_ctrl: directed bench for csi_rx_link_ctrl with small timeouts.
module tb_csi_rx_link_ctrl;
`ifdef CSI_LINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clock = 1'b0, reset_n, enable, clk_ok, sync_wait, packet_done, ecc_err, in_frame;
  logic link_reset, link_enable, locked, err_irq;
  logic [2:0] state;
  logic [7:0] resync_cnt;
  logic [15:0] frame_cnt;
  int checks = 0, errors = 0, cyc = 0, n, first, last;

  csi_rx_link_ctrl #(.RST_CYCLES(4), .SYNC_TIMEOUT(100), .FRAME_TIMEOUT(1000), .ECC_ERR_MAX(2)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clk_ok(clk_ok), .sync_wait(sync_wait),
    .packet_done(packet_done), .ecc_err(ecc_err), .in_frame(in_frame), .link_reset(link_reset),
    .link_enable(link_enable), .locked(locked), .state(state), .err_irq(err_irq),
    .resync_cnt(resync_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic step(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 0; enable = 0; clk_ok = 0; sync_wait = 1; packet_done = 0; ecc_err = 0; in_frame = 0;
    step(2);
    chk("rst_state", state, 0);
    chk("rst_link_reset", link_reset, 1);
    chk("rst_link_enable", link_enable, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_irq", err_irq, 0);
    chk("rst_resync", resync_cnt, 0);
    chk("rst_frame", frame_cnt, 0);
    reset_n = 1; step(1);
    chk("idle_hold", state, 0);
    enable = 1; clk_ok = 1;
    step(1);
    chk("bringup_reset", state, 1);
    chk("bringup_reset_lr", link_reset, 1);
    step(3);
    chk("reset_4th_cycle", state, 1);
    step(1);
    chk("sync_entry", state, 2);
    chk("sync_lr", link_reset, 0);
    chk("sync_le", link_enable, 1);
    step(9);
    chk("sync_wait_9", state, 2);
    sync_wait = 0;
    step(1);
    chk("locked_state", state, 3);
    chk("locked_flag", locked, 1);
    // error / clean / error keeps lock
    packet_done = 1; ecc_err = 1; step(1);
    chk("ecc_e1", state, 3);
    ecc_err = 0; step(1);
    chk("ecc_clean", state, 3);
    ecc_err = 1; step(1);
    chk("ecc_e2", state, 3);
    packet_done = 0; step(1);
    chk("ecc_gap", state, 3);
    packet_done = 1; step(1);
    chk("ecc_recover", state, 4);
    chk("ecc_irq", err_irq, 1);
    chk("ecc_recover_lr", link_reset, 1);
    chk("ecc_recover_le", link_enable, 0);
    chk("ecc_recover_locked", locked, 0);
    chk("ecc_resync", resync_cnt, STATS ? 1 : 0);
    packet_done = 0; ecc_err = 0;
    step(1);
    chk("recover_to_reset", state, 1);
    chk("irq_one_shot", err_irq, 0);
    step(4);
    chk("relock_sync", state, 2);
    step(1);
    chk("relock", state, 3);
    // frame watchdog: SOF on the last allowed cycle rescues the lock
    step(999);
    chk("wd_999", state, 3);
    in_frame = 1; step(1);
    chk("wd_sof_saves", state, 3);
    chk("wd_frame_cnt", frame_cnt, STATS ? 1 : 0);
    step(999);
    chk("wd_999b", state, 3);
    step(1);
    chk("wd_timeout", state, 4);
    chk("wd_irq", err_irq, 1);
    chk("wd_resync", resync_cnt, STATS ? 2 : 0);
    in_frame = 0;
    step(5);
    chk("wd_relock_sync", state, 2);
    step(1);
    chk("wd_relock", state, 3);
`ifdef CSI_LINK_STATS_EN
    dut.frame_cnt_q = 16'hFFFF;
`endif
    in_frame = 1; step(1);
    chk("frame_wrap", frame_cnt, 0);
    chk("frame_wrap_state", state, 3);
    // clk_ok drop aborts to IDLE
    clk_ok = 0; step(1);
    chk("abort_state", state, 0);
    chk("abort_lr", link_reset, 1);
    chk("abort_le", link_enable, 0);
    chk("abort_locked", locked, 0);
    clk_ok = 1; in_frame = 0; sync_wait = 1;
    step(1);
    chk("restart_reset", state, 1);
    step(4);
    chk("st_sync", state, 2);
    step(99);
    chk("st_sync_99", state, 2);
    step(1);
    chk("st_recover", state, 4);
    chk("st_irq", err_irq, 1);
    chk("st_resync", resync_cnt, STATS ? 3 : 0);
    step(1);
    chk("st_reset", state, 1);
    step(4);
    chk("st_sync_again", state, 2);
    step(10);
    reset_n = 0; #1;
    chk("async_state", state, 0);
    chk("async_lr", link_reset, 1);
    chk("async_le", link_enable, 0);
    chk("async_resync", resync_cnt, 0);
    chk("async_frame", frame_cnt, 0);
    @(negedge clock);
    reset_n = 1;
    // repeated ECC-forced recoveries: 8-cycle loop, resync_cnt saturates
    sync_wait = 0; packet_done = 1; ecc_err = 1; n = 0; first = 0; last = 0;
    for (int i = 0; i < 5000 && n < 300; i++) begin
      step(1);
      if (err_irq) begin
        n++;
        if (n == 1) first = cyc;
        last = cyc;
      end
    end
    chk("sat_irq_count", n, 300);
    chk("sat_period", last - first, 2392);
    chk("sat_resync", resync_cnt, STATS ? 255 : 0);
    packet_done = 0; ecc_err = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
